// File: rtl/dmux_dispatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : dmux_dispatch_ctrl_if
// Brief   : Stream, configuration and demux-side bundle of the dispatch controller.
// Revision: 1.0 - initial release
// ============================================================================
interface dmux_dispatch_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        cfg_mask;
  logic              cfg_fixed;
  logic [1:0]        cfg_sel;
  logic [3:0]        lane_ready;
  logic              dmux_en;
  logic [1:0]        dmux_sel;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_valid;
  logic [CNT_W-1:0]  sent_cnt;
  logic              stall;

  modport master (
    output in_valid, in_data, cfg_mask, cfg_fixed, cfg_sel, lane_ready,
    input  in_ready, dmux_en, dmux_sel, out_data, out_valid, sent_cnt, stall
  );

  modport slave (
    input  in_valid, in_data, cfg_mask, cfg_fixed, cfg_sel, lane_ready,
    output in_ready, dmux_en, dmux_sel, out_data, out_valid, sent_cnt, stall
  );
endinterface
`default_nettype wire

// File: rtl/dmux_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dmux_dispatch_ctrl
// Brief   : Holds one item and steers it through a 1-to-4 demux, lane chosen by
//           weighted round-robin over enabled lanes or by a fixed lane.
// Revision: 1.0 - initial release
// ============================================================================
module dmux_dispatch_ctrl #(
  parameter int DATA_W = 8,
  parameter int BURST  = 2,
  parameter int CNT_W  = 16
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  dmux_dispatch_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam logic [3:0] C_BURST = 4'(BURST);

  state_t            state_q, state_d;
  logic [1:0]        sel_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              stall_q;
  logic [1:0]        rr_q, rr_d;
  logic [3:0]        burst_q, burst_d;

  logic       rr_ok;
  logic [1:0] rr_lane;
  logic       sel_ok;
  logic [1:0] pick_lane;
  logic       load;
  logic       complete;
  logic [3:0] burst_nx;

  // Descending scan so the smallest offset from rr_q wins.
  always_comb begin
    rr_ok   = 1'b0;
    rr_lane = rr_q;
    for (int i = 3; i >= 0; i--) begin
      if (bus.cfg_mask[rr_q + 2'(i)]) begin
        rr_ok   = 1'b1;
        rr_lane = rr_q + 2'(i);
      end
    end
  end

  always_comb begin
    if (bus.cfg_fixed) begin
      sel_ok    = bus.cfg_mask[bus.cfg_sel];
      pick_lane = bus.cfg_sel;
    end else begin
      sel_ok    = rr_ok;
      pick_lane = rr_lane;
    end
  end

  assign complete     = (state_q == S_SEND) && bus.lane_ready[sel_q];
  assign bus.in_ready = sel_ok && ((state_q == S_IDLE) || complete);
  assign load         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (load) state_d = S_SEND;
      S_SEND: begin
        if (load)          state_d = S_SEND;
        else if (complete) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A lane reached by skipping disabled lanes starts a fresh burst.
  always_comb begin
    rr_d     = rr_q;
    burst_d  = burst_q;
    burst_nx = (pick_lane != rr_q) ? 4'd1 : burst_q + 4'd1;
    if (load && !bus.cfg_fixed) begin
      if (burst_nx >= C_BURST) begin
        burst_d = 4'd0;
        rr_d    = pick_lane + 2'd1;
      end else begin
        burst_d = burst_nx;
        rr_d    = pick_lane;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= 2'd0;
      burst_q <= 4'd0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      stall_q <= bus.in_valid && !sel_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 2'd0;
      data_q <= '0;
    end else if (load) begin
      sel_q  <= pick_lane;
      data_q <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (complete) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.dmux_en   = (state_q == S_SEND);
  assign bus.dmux_sel  = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == S_SEND) ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.sent_cnt  = cnt_q;
  assign bus.stall     = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_dmux_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmux_dispatch_ctrl
// Brief   : Two controllers (burst 2 and burst 1) on shared stimulus, each
//           compared every cycle with a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmux_dispatch_ctrl;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              d_valid = 1'b0;
  logic [DATA_W-1:0] d_data  = '0;
  logic [3:0]        d_mask  = 4'hF;
  logic              d_fixed = 1'b0;
  logic [1:0]        d_sel   = 2'd0;
  logic [3:0]        d_lr    = 4'hF;

  dmux_dispatch_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) if0 ();
  dmux_dispatch_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) if1 ();

  assign if0.in_valid = d_valid;  assign if1.in_valid = d_valid;
  assign if0.in_data = d_data;    assign if1.in_data = d_data;
  assign if0.cfg_mask = d_mask;   assign if1.cfg_mask = d_mask;
  assign if0.cfg_fixed = d_fixed; assign if1.cfg_fixed = d_fixed;
  assign if0.cfg_sel = d_sel;     assign if1.cfg_sel = d_sel;
  assign if0.lane_ready = d_lr;   assign if1.lane_ready = d_lr;

  dmux_dispatch_ctrl #(.DATA_W(DATA_W), .BURST(2), .CNT_W(CNT_W)) u_b2 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  dmux_dispatch_ctrl #(.DATA_W(DATA_W), .BURST(1), .CNT_W(CNT_W)) u_b1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Model: at most one held item per controller plus the rotation bookkeeping.
  int         BW[2] = '{2, 1};
  bit         m_send[2];
  int         m_lane[2];
  int         m_data[2];
  int         m_cnt[2];
  bit         m_stall[2];
  int         m_rr[2];
  int         m_run[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_send[k] = 0; m_lane[k] = 0; m_data[k] = 0; m_cnt[k] = 0;
      m_stall[k] = 0; m_rr[k] = 0; m_run[k] = 0;
    end
  endfunction

  function automatic void choose(input int k, output bit ok, output int lane);
    ok = 0; lane = 0;
    if (d_fixed) begin
      ok = d_mask[d_sel]; lane = int'(d_sel);
    end else begin
      for (int i = 0; i < 4; i++) begin
        int l;
        l = (m_rr[k] + i) % 4;
        if (!ok && d_mask[l]) begin ok = 1; lane = l; end
      end
    end
  endfunction

  task automatic get_obs(input int k, output logic rdy, output logic en, output logic [1:0] sel,
                         output logic [7:0] dat, output logic [3:0] ov, output logic [15:0] cnt,
                         output logic st);
    if (k == 0) begin
      rdy = if0.in_ready; en = if0.dmux_en; sel = if0.dmux_sel; dat = if0.out_data;
      ov = if0.out_valid; cnt = if0.sent_cnt; st = if0.stall;
    end else begin
      rdy = if1.in_ready; en = if1.dmux_en; sel = if1.dmux_sel; dat = if1.out_data;
      ov = if1.out_valid; cnt = if1.sent_cnt; st = if1.stall;
    end
  endtask

  task automatic check_and_step(input int k);
    bit ok, exp_rdy, ld, done;
    int lane;
    logic rdy, en, st;
    logic [1:0] sel;
    logic [7:0] dat;
    logic [3:0] ov;
    logic [15:0] cnt;
    choose(k, ok, lane);
    done    = m_send[k] && d_lr[m_lane[k]];
    exp_rdy = ok && (!m_send[k] || done);
    get_obs(k, rdy, en, sel, dat, ov, cnt, st);
    check($sformatf("in_ready[%0d]", k), rdy, exp_rdy);
    check($sformatf("dmux_en[%0d]", k), en, m_send[k]);
    check($sformatf("out_valid[%0d]", k), ov, m_send[k] ? (32'd1 << m_lane[k]) : 32'd0);
    check($sformatf("sent_cnt[%0d]", k), cnt, m_cnt[k]);
    check($sformatf("stall[%0d]", k), st, m_stall[k]);
    if (m_send[k]) begin
      check($sformatf("dmux_sel[%0d]", k), sel, m_lane[k]);
      check($sformatf("out_data[%0d]", k), dat, m_data[k]);
    end
    ld = d_valid && exp_rdy;
    if (done) m_cnt[k] = (m_cnt[k] + 1) % 65536;
    if (ld) begin
      m_send[k] = 1; m_data[k] = int'(d_data);
      if (!d_fixed) begin
        int run;
        run = (lane == m_rr[k]) ? m_run[k] + 1 : 1;
        if (run >= BW[k]) begin m_run[k] = 0; m_rr[k] = (lane + 1) % 4; end
        else begin m_run[k] = run; m_rr[k] = lane; end
      end
      m_lane[k] = lane;
    end else if (done) begin
      m_send[k] = 0;
    end
    m_stall[k] = d_valid && !ok;
  endtask

  task automatic cycle(input bit v, input logic [7:0] dt, input logic [3:0] mk, input bit fx,
                       input logic [1:0] sl, input logic [3:0] lr);
    @(negedge clk);
    d_valid = v; d_data = dt; d_mask = mk; d_fixed = fx; d_sel = sl; d_lr = lr;
    #1;
    check_and_step(0);
    check_and_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; d_valid = 1'b0;
    #1;
    check("rst_en", if0.dmux_en, 0);
    check("rst_sel", if0.dmux_sel, 0);
    check("rst_data", if0.out_data, 0);
    check("rst_ov", if1.out_valid, 0);
    check("rst_cnt", if1.sent_cnt, 0);
    check("rst_stall", if0.stall, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_seq[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  initial begin
    model_reset();
    do_reset();

    // Round-robin burst of two across all lanes, one item per cycle.
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'(8'h10 + i), 4'hF, 0, 2'd0, 4'hF);
      check("rr_seq", if0.dmux_sel, exp_seq[i]);
    end
    cycle(0, 8'h00, 4'hF, 0, 2'd0, 4'hF);
    check("rr_cnt", if0.sent_cnt, 8);

    // Async reset while an item is held.
    cycle(1, 8'h33, 4'hF, 0, 2'd0, 4'h0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_en", if0.dmux_en, 0);
    check("arst_ov", if0.out_valid, 0);
    check("arst_cnt", if0.sent_cnt, 0);
    do_reset();

    // Sparse mask with burst 1: lanes 1,3,1.
    cycle(1, 8'hA0, 4'b1010, 0, 2'd0, 4'hF);
    check("sparse_a", if1.out_valid, 4'b0010);
    cycle(1, 8'hB0, 4'b1010, 0, 2'd0, 4'hF);
    check("sparse_b", if1.out_valid, 4'b1000);
    cycle(1, 8'hC0, 4'b1010, 0, 2'd0, 4'hF);
    check("sparse_c", if1.out_valid, 4'b0010);
    do_reset();

    // Backpressure on lane 0.
    cycle(1, 8'h5A, 4'hF, 0, 2'd0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 8'h99, 4'hF, 0, 2'd0, 4'b1110);
      check("bp_rdy", if0.in_ready, 0);
      check("bp_data", if0.out_data, 8'h5A);
      check("bp_ov", if0.out_valid, 4'b0001);
    end
    cycle(0, 8'h00, 4'hF, 0, 2'd0, 4'hF);
    check("bp_cnt", if0.sent_cnt, 1);
    do_reset();

    // Fixed lane 2, then round-robin still starts at lane 0; then empty mask.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 8'(8'h40 + i), 4'b0100, 1, 2'd2, 4'hF);
      check("fix_ov", if0.out_valid, 4'b0100);
    end
    cycle(1, 8'h50, 4'hF, 0, 2'd0, 4'hF);
    check("fix_rr", if0.dmux_sel, 0);
    cycle(1, 8'h51, 4'h0, 0, 2'd0, 4'hF);
    check("nomask_rdy", if0.in_ready, 0);
    check("nomask_stall", if0.stall, 1);
    do_reset();

    // Mask change while an item is held on lane 3.
    cycle(1, 8'h66, 4'hF, 1, 2'd3, 4'h0);
    cycle(1, 8'h77, 4'b0001, 0, 2'd0, 4'b0111);
    check("mchg_sel", if0.dmux_sel, 3);
    check("mchg_data", if0.out_data, 8'h66);
    cycle(1, 8'h77, 4'b0001, 0, 2'd0, 4'b1000);
    check("mchg_next", if0.dmux_sel, 0);
    check("mchg_cnt", if0.sent_cnt, 1);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] mk;
      mk = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      cycle($urandom_range(0, 9) < 7, 8'($urandom), mk, $urandom_range(0, 3) == 0,
            2'($urandom), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dmux_dispatch_ctrl.md
Name: dmux_dispatch_ctrl

Overview:
Controller that drives the 1-to-4 demultiplexer in front of four sink lanes. Accepts items on a valid/ready input stream and holds each item in an output register. Picks the destination lane by weighted round-robin over enabled lanes, or by a fixed configured lane. Drives the demux enable/select and a one-hot lane valid, and completes each transfer when the selected lane accepts it.

Parameters:
DATA_W, 8, width of the data item routed through the demux
BURST, 2, consecutive items sent to one lane before rotating (1..15)
CNT_W, 16, width of the per-controller dispatched-item counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous and active-low; one clock domain only
in_valid  input  1  upstream item present
in_data  input  DATA_W  upstream item
in_ready  output  1  controller can take an item this cycle (combinational)
cfg_mask  input  4  lane enable mask, bit i enables lane i
cfg_fixed  input  1  1 = fixed-lane mode, 0 = round-robin mode
cfg_sel  input  2  lane used when cfg_fixed=1
lane_ready  input  4  per-lane sink ready
dmux_en  output  1  demux enable (registered)
dmux_sel  output  2  demux select, s[1:0] (registered)
out_data  output  DATA_W  held item presented to demux i_in path
out_valid  output  4  one-hot: bit dmux_sel set when dmux_en=1, else 0
sent_cnt  output  CNT_W  total items completed since reset, wraps
stall  output  1  in_valid=1 but no lane is selectable (registered)

Behaviour:
- Reset (rst_n low, async): state=IDLE, dmux_en=0, dmux_sel=0, out_data=0, out_valid=0, sent_cnt=0, stall=0, rr_ptr=0, burst_cnt=0. Reset mid-transfer drops the held item.
- States: IDLE (output register empty) and SEND (item held, dmux_en=1).
- Selectable lane:
  - Fixed mode: cfg_sel if cfg_mask[cfg_sel]=1, else none.
  - RR mode: the first enabled lane at or after rr_ptr, in cyclic order 0..3.
- in_ready = sel_ok && (state==IDLE || (state==SEND && lane_ready[dmux_sel])), where sel_ok means a selectable lane exists.
- Load: when in_valid && in_ready, on the next edge out_data<=in_data, dmux_sel<=chosen lane, dmux_en<=1, state=SEND. Latency input→out_valid is 1 cycle.
- Complete: in SEND, a transfer completes in a cycle with lane_ready[dmux_sel]=1. sent_cnt increments by 1 (wraps at 2^CNT_W).
  - If a load happens in the same cycle, stay in SEND with the new item (back-to-back, 1 item/cycle).
  - Otherwise go to IDLE and clear dmux_en.
- While SEND waits, out_data and dmux_sel hold stable. Changes to lane_ready on other lanes, cfg_mask or cfg_fixed do not move the held item.
- Round-robin weighting, on each load in RR mode:
  - burst_cnt increments.
  - When burst_cnt reaches BURST, burst_cnt<=0 and rr_ptr<=chosen+1 (mod 4).
  - Otherwise rr_ptr<=chosen, so the same lane repeats.
  - If the chosen lane differs from rr_ptr (skipped disabled lanes), burst_cnt restarts: it becomes 1, or 0 with rotation if BURST=1.
- Fixed mode loads do not change rr_ptr or burst_cnt.
- Config changes take effect at the next selection, never on a held item.
- stall <= in_valid && !sel_ok, evaluated every cycle. cfg_mask=0 stalls intake indefinitely; no data is lost.

Test Plan:
1. Reset: rst_n=0 asserted mid-SEND → dmux_en, out_valid, sent_cnt go 0 asynchronously, before the next clk edge.
2. RR, BURST=2, cfg_mask=4'b1111, all lane_ready=1, items 0x10..0x17 streamed → dmux_sel sequence 0,0,1,1,2,2,3,3; one item per cycle; sent_cnt=8.
3. RR, cfg_mask=4'b1010, BURST=1, items A,B,C → lanes 1,3,1; out_valid 4'b0010, 4'b1000, 4'b0010.
4. Backpressure: item 0x5A to lane 0, lane_ready[0]=0 for 3 cycles → in_ready=0, out_data=0x5A and out_valid=4'b0001 held; lane_ready[0]=1 → complete, sent_cnt+1.
5. Fixed mode, cfg_sel=2, cfg_mask=4'b0100 → every item goes to lane 2 (out_valid=4'b0100); rr_ptr unchanged. cfg_mask=4'b0000 with in_valid=1 → in_ready=0, stall=1 next cycle.
6. Mask change during SEND: held item on lane 3, cfg_mask 1111→0001 → item still completes on lane 3; the next item goes to lane 0.
